nibble_serial_sub: RTL and testbench
====================================

// Module: nibble_serial_sub
// PURPOSE
//   Sequencer sitting directly upstream of the 4-bit borrow-lookahead subtractor (BLS).
//   - Accepts one WIDTH-bit subtraction per handshake.
//   - Feeds the subtractor one nibble per clock, LSB nibble first.
//   - Chains the borrow between nibbles and assembles the WIDTH-bit difference plus final borrow.
//   - Lets any BLS variant (gate-level, dataflow or behavioural) compute wide operands serially.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; multiple of 4, >= 8; NIB = WIDTH/4 nibbles
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand set present on in_a/in_b/in_bin
//   in_ready   out  1      block can accept operands
//   in_a       in   WIDTH  minuend
//   in_b       in   WIDTH  subtrahend
//   in_bin     in   1      borrow-in to LSB nibble
//   sub_a      out  4      nibble A to BLS
//   sub_b      out  4      nibble B to BLS
//   sub_bin    out  1      borrow-in to BLS
//   sub_d      in   4      BLS difference, combinational from sub_a/sub_b/sub_bin
//   sub_bout   in   1      BLS borrow-out, combinational
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer takes result
//   out_diff   out  WIDTH  difference
//   out_bout   out  1      final borrow-out
//   out_zero   out  1      out_diff == 0
// BEHAVIOUR
//   - Interface: one clock (clk). Reset (rst) is synchronous and active-high.
//   - FSM states: IDLE, RUN, DONE. On reset: state=IDLE; nibble index=0; diff_reg=0; borrow_reg=0.
//   - Outputs under reset:
//     - in_ready = 0 while rst is high.
//     - out_valid=0, out_diff=0, out_bout=0, out_zero=0.
//     - sub_a=0, sub_b=0, sub_bin=0.
//   - IDLE:
//     - in_ready=1.
//     - On in_valid & in_ready: latch in_a, in_b; borrow_reg <= in_bin; idx <= 0; go to RUN.
//   - RUN:
//     - in_ready=0.
//     - Drive sub_a = a_reg[4*idx+:4], sub_b = b_reg[4*idx+:4], sub_bin = borrow_reg.
//     - Each edge: diff_reg[4*idx+:4] <= sub_d; borrow_reg <= sub_bout; idx <= idx+1.
//     - At the edge where idx == NIB-1: go to DONE. idx wraps to 0.
//   - DONE:
//     - out_valid=1; out_diff=diff_reg; out_bout=borrow_reg; out_zero=(diff_reg==0).
//     - Outputs hold stable until out_ready=1.
//     - On out_valid & out_ready: go to IDLE. No same-cycle accept; in_ready rises the next cycle.
//   - In IDLE and DONE: sub_a, sub_b, sub_bin driven 0.
//     - out_valid=0 in IDLE and RUN.
//     - out_diff/out_bout/out_zero hold the last result in IDLE (0 after reset).
//   - Latency: out_valid rises exactly NIB cycles after the accepting edge (4 for WIDTH=16).
//     - Throughput: one op per NIB+2 cycles minimum.
//   - Arithmetic: {out_bout,out_diff} = A - B - bin, modulo 2^WIDTH.
//     - out_bout=1 iff A < B + bin (unsigned). No signed interpretation.
//   - in_valid while in_ready=0 is ignored; in_a/in_b need only be stable on the accepting edge.
//   - rst mid-RUN or mid-DONE: operation discarded, no out_valid pulse.
//     - in_ready=1 on the first cycle after rst deasserts.
//   - sub_d/sub_bout are sampled only in RUN; X on them outside RUN must not propagate.
// TESTING  (WIDTH=16, BLS instance wired to sub_* ports, out_ready=1 unless stated)
//   1. A=0x1234 B=0x0234 bin=0 -> diff=0x1000 bout=0 zero=0.
//      - out_valid exactly 4 cycles after accept; pulse lasts 1 cycle.
//   2. A=0x0000 B=0x0001 bin=0 -> diff=0xFFFF bout=1 (borrow ripples through all 4 nibbles).
//   3. A=0xFFFF B=0xFFFF bin=1 -> diff=0xFFFF bout=1.
//      A=0x8000 B=0x7FFF bin=1 -> diff=0x0000 bout=0 zero=1.
//   4. Backpressure: out_ready=0 for 10 cycles -> out_valid/out_diff/out_bout stable.
//      - in_ready=0 throughout; a new in_valid pulse is ignored.
//      - Release -> IDLE next cycle.
//   5. Assert rst for 1 cycle after 2 RUN cycles -> out_valid stays 0; in_ready=1 next cycle.
//      - A following op A=0x00F0 B=0x000F bin=0 gives diff=0x00E1 bout=0.
//   6. 1000 random back-to-back ops vs model (A-B-bin) mod 2^16.
//      - Check latency and that sub_bin of nibble k equals sub_bout of nibble k-1.

Source files
------------

// File: rtl/nibble_serial_sub_if.sv
// Operand, borrow-lookahead-subtractor and result signals of the nibble-serial subtractor.
// slave is the sequencer side; master is the operand source, result sink and BLS side.
interface nibble_serial_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_bin;

    logic [3:0]       sub_a;
    logic [3:0]       sub_b;
    logic             sub_bin;
    logic [3:0]       sub_d;
    logic             sub_bout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_bout;
    logic             out_zero;

    modport slave (
        input  in_valid, in_a, in_b, in_bin, sub_d, sub_bout, out_ready,
        output in_ready, sub_a, sub_b, sub_bin, out_valid, out_diff, out_bout, out_zero
    );

    modport master (
        output in_valid, in_a, in_b, in_bin, sub_d, sub_bout, out_ready,
        input  in_ready, sub_a, sub_b, sub_bin, out_valid, out_diff, out_bout, out_zero
    );
endinterface

// File: rtl/nibble_serial_sub.sv
// Nibble-serial WIDTH-bit subtractor sequencer: feeds an external 4-bit BLS one nibble per
// clock, LSB first, chaining the borrow and assembling the difference plus final borrow.
module nibble_serial_sub #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    nibble_serial_sub_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;
    logic [WIDTH-1:0] res_diff;
    logic             res_bout;
    logic             res_zero;
    logic [WIDTH-1:0] diff_nxt;
    logic             accept;
    logic             last_nib;

    assign accept   = bus.in_valid && (state == IDLE);
    assign last_nib = (state == RUN) && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = RUN;
            RUN:  if (last_nib) state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current nibble merged into the partial difference; only consumed in RUN, so an
    // undriven sub_d outside RUN never reaches any register.
    always_comb begin
        diff_nxt = diff_reg;
        diff_nxt[4*idx +: 4] = bus.sub_d;
    end

    // The result registers are separate from diff_reg so the last result (and its zero
    // flag) keeps showing in IDLE and during the next RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            res_diff   <= '0;
            res_bout   <= 1'b0;
            res_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= bus.in_a;
                        b_reg      <= bus.in_b;
                        borrow_reg <= bus.in_bin;
                        idx        <= '0;
                    end
                end
                RUN: begin
                    diff_reg   <= diff_nxt;
                    borrow_reg <= bus.sub_bout;
                    if (last_nib) begin
                        idx      <= '0;
                        res_diff <= diff_nxt;
                        res_bout <= bus.sub_bout;
                        res_zero <= (diff_nxt == '0);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.sub_a     = 4'h0;
        bus.sub_b     = 4'h0;
        bus.sub_bin   = 1'b0;
        bus.out_diff  = '0;
        bus.out_bout  = 1'b0;
        bus.out_zero  = 1'b0;
        if (!rst) begin
            bus.out_diff = res_diff;
            bus.out_bout = res_bout;
            bus.out_zero = res_zero;
            case (state)
                IDLE: bus.in_ready = 1'b1;
                RUN: begin
                    bus.sub_a   = a_reg[4*idx +: 4];
                    bus.sub_b   = b_reg[4*idx +: 4];
                    bus.sub_bin = borrow_reg;
                end
                DONE: bus.out_valid = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Scoreboard bench for nibble_serial_sub with a behavioural 4-bit BLS on the sub_* side;
// also tracks per-nibble operands, borrow chaining and accept-to-valid latency.
module tb_nibble_serial_sub;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    exp_t exp_q[$];

    logic             in_flight   = 1'b0;
    int               accept_edge = 0;
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic             cur_bin;
    logic             prev_bout;
    logic [4:0]       bls_res;

    nibble_serial_sub_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bls_res      = {1'b0, bus.sub_a} - {1'b0, bus.sub_b} - {4'b0, bus.sub_bin};
    assign bus.sub_d    = bls_res[3:0];
    assign bus.sub_bout = bls_res[4];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t         e;
        logic [WIDTH:0] full;
        bit           got = 1'b0;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.diff = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.zero = (full[WIDTH-1:0] == '0);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_bin   = bin;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) got = 1'b1;
        end
        if (got) exp_q.push_back(e);
        else checkOutput("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = WIDTH'($urandom);
        bus.in_b     = WIDTH'($urandom);
        bus.in_bin   = 1'($urandom);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    // Monitor: per-nibble BLS feed, latency, and scoreboard pop on each result handshake.
    always @(negedge clk) begin
        int k;
        exp_t e;
        if (rst) begin
            in_flight = 1'b0;
        end else begin
            if (in_flight) begin
                k = cyc - accept_edge;
                if (bus.out_valid === 1'b1) begin
                    checkOutput("latency", k, NIB);
                    in_flight = 1'b0;
                end else if (k < NIB) begin
                    checkOutput("sub_a", bus.sub_a, cur_a[4*k +: 4]);
                    checkOutput("sub_b", bus.sub_b, cur_b[4*k +: 4]);
                    checkOutput("sub_bin_chain", bus.sub_bin, (k == 0) ? cur_bin : prev_bout);
                    prev_bout = bus.sub_bout;
                end else begin
                    checkOutput("latency", k, NIB);
                    in_flight = 1'b0;
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                in_flight   = 1'b1;
                accept_edge = cyc + 1;
                cur_a       = bus.in_a;
                cur_b       = bus.in_b;
                cur_bin     = bus.in_bin;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_diff", bus.out_diff, e.diff);
                    checkOutput("out_bout", bus.out_bout, e.bout);
                    checkOutput("out_zero", bus.out_zero, e.zero);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got time limit reached, expected run completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] held_diff;
        bit               seen;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_bin    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_diff", bus.out_diff, 0);
        checkOutput("rst_out_bout", bus.out_bout, 0);
        checkOutput("rst_out_zero", bus.out_zero, 0);
        checkOutput("rst_sub_bus", {bus.sub_a, bus.sub_b, bus.sub_bin}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 1);
        checkOutput("idle_out_zero", bus.out_zero, 0);
        @(posedge clk);
        #1;

        // Directed corners, each drained so the single-cycle pulse and IDLE hold are visible.
        applyStimulus(16'h1234, 16'h0234, 1'b0);
        waitDrain();
        @(negedge clk);
        checkOutput("t1_pulse_len", bus.out_valid, 0);
        checkOutput("t1_hold_diff", bus.out_diff, 16'h1000);
        @(posedge clk);
        #1;
        applyStimulus(16'h0000, 16'h0001, 1'b0);
        waitDrain();
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1);
        waitDrain();
        applyStimulus(16'h8000, 16'h7FFF, 1'b1);
        waitDrain();
        @(negedge clk);
        checkOutput("t3_hold_zero", bus.out_zero, 1);
        @(posedge clk);
        #1;

        // Backpressure: result must hold and a new in_valid must be ignored.
        bus.out_ready = 1'b0;
        applyStimulus(16'hA5C3, 16'h1234, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        checkOutput("t4_valid_seen", seen, 1);
        held_diff = 16'hA5C3 - 16'h1234 - 16'h1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i >= 2 && i < 5);
            bus.in_a     = 16'h0F0F;
            bus.in_b     = 16'h0101;
            @(negedge clk);
            checkOutput("t4_hold_valid", bus.out_valid, 1);
            checkOutput("t4_hold_diff", bus.out_diff, held_diff);
            checkOutput("t4_hold_bout", bus.out_bout, 0);
            checkOutput("t4_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t4_release_ready", bus.in_ready, 1);
        checkOutput("t4_release_valid", bus.out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("t4_no_ghost", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of RUN discards the operation.
        applyStimulus(16'h4321, 16'h1111, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_rst_in_ready", bus.in_ready, 0);
        checkOutput("t5_rst_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_in_ready_after", bus.in_ready, 1);
        checkOutput("t5_diff_cleared", bus.out_diff, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t5_no_valid", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        applyStimulus(16'h00F0, 16'h000F, 1'b0);
        waitDrain();

        // Random back-to-back traffic against the A - B - bin model.
        for (int n = 0; n < 1000; n++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        end
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
